// File: rtl/sram_access_ctrl_if.sv
// Bundle of the CPU-side request bus and the external SRAM pins for sram_access_ctrl.
// The slave modport is the controller's view; master is the surrounding system (CPU FSM plus SRAM).
interface sram_access_ctrl_if #(
  parameter int W      = 16,
  parameter int ADDR_W = 20
);
  logic              Req;
  logic              Wr;
  logic [ADDR_W-1:0] Addr;
  logic [W-1:0]      Wdata;
  logic              Busy;
  logic              Done;
  logic [W-1:0]      Rdata;
  logic              Rdata_Load;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_CE_N;
  logic              Mem_OE_N;
  logic              Mem_WE_N;
  logic [W-1:0]      Mem_Dout;
  logic              Mem_Dout_En;
  logic [W-1:0]      Mem_Din;

  modport master (
    output Req, Wr, Addr, Wdata, Mem_Din,
    input  Busy, Done, Rdata, Rdata_Load,
    input  Mem_Addr, Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Dout, Mem_Dout_En
  );

  modport slave (
    input  Req, Wr, Addr, Wdata, Mem_Din,
    output Busy, Done, Rdata, Rdata_Load,
    output Mem_Addr, Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Dout, Mem_Dout_En
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer: latches a request, runs SETUP / ACCESS(WAIT) / HOLD on the SRAM strobes,
// and hands read data to the MDR with a one-cycle load pulse. Every output is a flop.
module sram_access_ctrl #(
  parameter int W      = 16,
  parameter int ADDR_W = 20,
  parameter int WAIT   = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  sram_access_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WAIT) + 1;

  if (WAIT < 1) begin : g_wait_check
    $error("sram_access_ctrl: WAIT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [W-1:0]      wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [W-1:0]      rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rdata_load_q, rdata_load_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dout_en_q, dout_en_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Req) begin
          addr_d  = bus.Addr;
          wdata_d = bus.Wdata;
          wr_d    = bus.Wr;
          cnt_d   = CNT_W'(WAIT - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          // Sample the SRAM while OE is still low, on the edge that ends ACCESS.
          if (!wr_q) begin
            rdata_d = bus.Mem_Din;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear, registered, in that state's cycle.
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == HOLD);
    rdata_load_d = (state_d == HOLD) && !wr_d;
    ce_n_d       = (state_d == IDLE);
    oe_n_d       = !((state_d == ACCESS) && !wr_d);
    we_n_d       = !((state_d == ACCESS) && wr_d);
    dout_en_d    = (state_d != IDLE) && wr_d;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_load_q <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dout_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdata_load_q <= rdata_load_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      dout_en_q    <= dout_en_d;
    end
  end

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Rdata       = rdata_q;
  assign bus.Rdata_Load  = rdata_load_q;
  assign bus.Mem_Addr    = addr_q;
  assign bus.Mem_CE_N    = ce_n_q;
  assign bus.Mem_OE_N    = oe_n_q;
  assign bus.Mem_WE_N    = we_n_q;
  assign bus.Mem_Dout    = wdata_q;
  assign bus.Mem_Dout_En = dout_en_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: a WAIT=2 and a WAIT=1 instance, each with a small SRAM model,
// a downstream MDR register, and a read-data scoreboard.
module tb_sram_access_ctrl;

  localparam int W  = 16;
  localparam int AW = 20;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  sram_access_ctrl_if #(.W(W), .ADDR_W(AW)) bus2 ();
  sram_access_ctrl_if #(.W(W), .ADDR_W(AW)) bus1 ();

  sram_access_ctrl #(.W(W), .ADDR_W(AW), .WAIT(2)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));
  sram_access_ctrl #(.W(W), .ADDR_W(AW), .WAIT(1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

  // SRAM models: preloaded while reset is held, written while CE/WE are low.
  logic [15:0] mem2 [0:255];
  logic [15:0] mem1 [0:255];

  always @(posedge Clk) begin
    if (!Reset) begin
      mem2[8'h23] <= 16'hBEEF;
      mem2[8'h10] <= 16'h5555;
      mem2[8'h11] <= 16'hAAAA;
    end else if (!bus2.Mem_CE_N && !bus2.Mem_WE_N && bus2.Mem_Dout_En) begin
      mem2[bus2.Mem_Addr[7:0]] <= bus2.Mem_Dout;
    end
  end

  always @(posedge Clk) begin
    if (!Reset) begin
      mem1[8'h23] <= 16'hC0DE;
    end
  end

  assign bus2.Mem_Din = (!bus2.Mem_CE_N && !bus2.Mem_OE_N) ? mem2[bus2.Mem_Addr[7:0]] : 16'hDEAD;
  assign bus1.Mem_Din = (!bus1.Mem_CE_N && !bus1.Mem_OE_N) ? mem1[bus1.Mem_Addr[7:0]] : 16'hDEAD;

  // Downstream MDR and pulse counters, sampled on the edge that consumes the pulses.
  logic [15:0] mdr2 = 16'h0000;
  int done2_cnt = 0;
  int rl2_cnt   = 0;
  int done1_cnt = 0;

  always @(posedge Clk) begin
    if (bus2.Rdata_Load) mdr2 <= bus2.Rdata;
    if (bus2.Done) done2_cnt <= done2_cnt + 1;
    if (bus2.Rdata_Load) rl2_cnt <= rl2_cnt + 1;
    if (bus1.Done) done1_cnt <= done1_cnt + 1;
  end

  int tests = 0;
  int fails = 0;
  logic [15:0] sb2[$];
  logic [15:0] sb1[$];
  logic [15:0] last_rd2 = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {CE_N, OE_N, WE_N, Dout_En, Busy, Done, Rdata_Load} in cycle c after Req was sampled.
  function automatic logic [6:0] exp_vec(input int c, input logic wr, input int wt);
    logic act, live, hold;
    act  = (c >= 2) && (c <= wt + 1);
    live = (c >= 1) && (c <= wt + 2);
    hold = (c == wt + 2);
    return {!live, !(act && !wr), !(act && wr), live && wr, live, hold, hold && !wr};
  endfunction

  function automatic logic [6:0] obs2();
    return {bus2.Mem_CE_N, bus2.Mem_OE_N, bus2.Mem_WE_N, bus2.Mem_Dout_En,
            bus2.Busy, bus2.Done, bus2.Rdata_Load};
  endfunction

  function automatic logic [6:0] obs1();
    return {bus1.Mem_CE_N, bus1.Mem_OE_N, bus1.Mem_WE_N, bus1.Mem_Dout_En,
            bus1.Busy, bus1.Done, bus1.Rdata_Load};
  endfunction

  task automatic pop_check2();
    logic [15:0] e;
    tests++;
    assert (sb2.size() != 0) else begin
      fails++;
      $error("FAIL sb2_underflow: observed Rdata_Load with %0d pending, expected at least 1", sb2.size());
    end
    if (sb2.size() != 0) begin
      e = sb2.pop_front();
      check("rdata2", 32'(bus2.Rdata), 32'(e));
      last_rd2 = e;
    end
  endtask

  task automatic pop_check1();
    logic [15:0] e;
    tests++;
    assert (sb1.size() != 0) else begin
      fails++;
      $error("FAIL sb1_underflow: observed Rdata_Load with %0d pending, expected at least 1", sb1.size());
    end
    if (sb1.size() != 0) begin
      e = sb1.pop_front();
      check("rdata1", 32'(bus1.Rdata), 32'(e));
    end
  endtask

  // Leaves the caller at the falling edge inside cycle 1 (SETUP).
  task automatic start_req2(input logic wr, input logic [19:0] a, input logic [15:0] d);
    @(negedge Clk);
    bus2.Req = 1'b1; bus2.Wr = wr; bus2.Addr = a; bus2.Wdata = d;
    @(negedge Clk);
    bus2.Req = 1'b0;
  endtask

  task automatic txn2(input string tag, input logic wr, input logic [19:0] a, input logic [15:0] d,
                      input logic [15:0] rd_exp, input bit glitch);
    int d0;
    d0 = done2_cnt;
    if (!wr) sb2.push_back(rd_exp);
    start_req2(wr, a, d);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge Clk);
      check({tag, "_strobes"}, 32'(obs2()), 32'(exp_vec(c, wr, 2)));
      if (c <= 4) check({tag, "_mem_addr"}, 32'(bus2.Mem_Addr), 32'(a));
      if (wr && c <= 4) check({tag, "_mem_dout"}, 32'(bus2.Mem_Dout), 32'(d));
      if (bus2.Rdata_Load) pop_check2();
      if (c == 5 && wr) check({tag, "_rdata_kept"}, 32'(bus2.Rdata), 32'(last_rd2));
      if (c == 5 && !wr) check({tag, "_mdr"}, 32'(mdr2), 32'(rd_exp));
      if (glitch && c == 2) begin
        bus2.Req = 1'b1; bus2.Addr = a ^ 20'h1; bus2.Wr = ~wr; bus2.Wdata = ~d;
      end else if (glitch && c == 3) begin
        bus2.Req = 1'b0;
      end
    end
    repeat (3) @(negedge Clk);
    check({tag, "_done_count"}, 32'(done2_cnt - d0), 32'd1);
  endtask

  int first_done, second_done, d_base, r_base;

  initial begin
    bus2.Req = 1'b0; bus2.Wr = 1'b0; bus2.Addr = '0; bus2.Wdata = '0;
    bus1.Req = 1'b0; bus1.Wr = 1'b0; bus1.Addr = '0; bus1.Wdata = '0;

    // Reset state
    #1 Reset = 1'b0;
    #1;
    check("reset_strobes2", 32'(obs2()), 32'(7'b1110000));
    check("reset_strobes1", 32'(obs1()), 32'(7'b1110000));
    check("reset_rdata2", 32'(bus2.Rdata), 32'h0);
    check("reset_addr2", 32'(bus2.Mem_Addr), 32'h0);
    check("reset_dout2", 32'(bus2.Mem_Dout), 32'h0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;

    // Basic read, write, read-back, then a read with a stray Req mid-transaction
    txn2("read_beef", 1'b0, 20'h00123, 16'h0000, 16'hBEEF, 1'b0);
    txn2("write_1234", 1'b1, 20'h00040, 16'h1234, 16'h0000, 1'b0);
    txn2("readback_1234", 1'b0, 20'h00040, 16'h0000, 16'h1234, 1'b0);
    txn2("read_ignore_req", 1'b0, 20'h00010, 16'h0000, 16'h5555, 1'b1);

    // Req held high across two reads
    d_base = done2_cnt;
    first_done = -1;
    second_done = -1;
    sb2.push_back(16'h5555);
    sb2.push_back(16'hAAAA);
    @(negedge Clk);
    bus2.Req = 1'b1; bus2.Wr = 1'b0; bus2.Addr = 20'h00010;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      if (bus2.Rdata_Load) pop_check2();
      if (bus2.Done) begin
        if (first_done < 0) begin
          first_done = c;
          bus2.Addr = 20'h00011;
        end else if (second_done < 0) begin
          second_done = c;
        end
      end
      if (c == 6) bus2.Req = 1'b0;
    end
    check("b2b_first_done_cycle", 32'(first_done), 32'd4);
    check("b2b_done_gap", 32'(second_done - first_done), 32'd5);
    check("b2b_done_count", 32'(done2_cnt - d_base), 32'd2);
    check("b2b_rdata_final", 32'(bus2.Rdata), 32'hAAAA);

    // WAIT=1 instance: single read
    d_base = done1_cnt;
    sb1.push_back(16'hC0DE);
    @(negedge Clk);
    bus1.Req = 1'b1; bus1.Wr = 1'b0; bus1.Addr = 20'h00023;
    @(negedge Clk);
    bus1.Req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge Clk);
      check("w1_strobes", 32'(obs1()), 32'(exp_vec(c, 1'b0, 1)));
      if (bus1.Rdata_Load) pop_check1();
    end
    repeat (2) @(negedge Clk);
    check("w1_done_count", 32'(done1_cnt - d_base), 32'd1);

    // Asynchronous reset during a read in ACCESS
    start_req2(1'b0, 20'h00123, 16'h0000);
    @(negedge Clk);
    check("abort_in_access", 32'(obs2()), 32'(exp_vec(2, 1'b0, 2)));
    check("abort_rdata_before", 32'(bus2.Rdata), 32'hAAAA);
    #2 Reset = 1'b0;
    #1;
    check("abort_strobes", 32'(obs2()), 32'(7'b1110000));
    check("abort_rdata", 32'(bus2.Rdata), 32'h0);
    d_base = done2_cnt;
    r_base = rl2_cnt;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (6) @(negedge Clk);
    check("abort_no_done", 32'(done2_cnt), 32'(d_base));
    check("abort_no_load", 32'(rl2_cnt), 32'(r_base));
    check("abort_idle", 32'(obs2()), 32'(7'b1110000));

    check("sb2_drained", 32'(sb2.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish by 100000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Memory-access sequencer between the CPU control FSM and the external 16-bit SRAM.
- On a request it:
  - latches the address and write data,
  - drives the SRAM strobes through a setup, wait-state and hold sequence,
  - for reads, delivers the captured word with a one-cycle load pulse to the downstream MDR register.
- It is the stage directly upstream of the MDR register and feeds its In/Load pins.

Parameters:
- W, 16, data width.
- ADDR_W, 20, SRAM address width.
- WAIT, 2, number of ACCESS cycles with strobes active. Must be >= 1; an elaboration-time check fails on 0.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  1  request strobe, sampled only in IDLE.
- Wr  input  1  1=write, 0=read; sampled with Req.
- Addr  input  ADDR_W  word address; sampled with Req.
- Wdata  input  W  write data; sampled with Req.
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse marking completion (reads and writes).
- Rdata  output  W  last word read; feeds MDR In.
- Rdata_Load  output  1  one-cycle pulse, reads only; feeds MDR Load.
- Mem_Addr  output  ADDR_W  SRAM address, driven from the latched request.
- Mem_CE_N  output  1  SRAM chip enable, active-low.
- Mem_OE_N  output  1  SRAM output enable, active-low.
- Mem_WE_N  output  1  SRAM write enable, active-low.
- Mem_Dout  output  W  write data to the SRAM bus.
- Mem_Dout_En  output  1  tristate enable for Mem_Dout.
- Mem_Din  input  W  read data from the SRAM bus.

Behaviour:
- Reset (Reset=0, asynchronous, takes effect immediately without a clock edge):
  - state=IDLE, counter=0;
  - Rdata=0, latched Addr/Wdata/Wr=0;
  - Busy=0, Done=0, Rdata_Load=0;
  - Mem_CE_N=Mem_OE_N=Mem_WE_N=1, Mem_Dout_En=0.
- Reset asserted mid-transaction: the transaction is abandoned. No Done, no Rdata_Load, Rdata cleared, and all strobes return inactive at once.
- All outputs decode from registered state, the counter and latched fields only. They are never driven combinationally from Req, Wr, Addr or Wdata.
- States: IDLE, SETUP, ACCESS, HOLD.
  - IDLE:
    - strobes inactive, Busy=0.
    - On a rising edge with Req=1: latch Addr, Wr, Wdata; load counter with WAIT-1; go to SETUP.
  - SETUP (1 cycle):
    - Mem_CE_N=0, address stable, OE_N=WE_N=1.
    - Mem_Dout_En=latched Wr.
    - Next state: ACCESS.
  - ACCESS (WAIT cycles):
    - Mem_CE_N=0, Mem_OE_N=latched Wr, Mem_WE_N=~latched Wr, Mem_Dout_En=latched Wr.
    - Counter decrements each cycle; at counter=0 go to HOLD.
    - For a read, Mem_Din is registered into Rdata on the edge leaving ACCESS.
  - HOLD (1 cycle):
    - Mem_CE_N=0, OE_N=WE_N=1; Mem_Dout_En stays at latched Wr, so write data is held one cycle past the WE rising edge.
    - Done=1; Rdata_Load=~latched Wr.
    - Next state: IDLE.
- Latency: with Req sampled at edge 0, Done is high during cycle WAIT+2 (WAIT=2 gives cycle 4). Rdata is valid from that same cycle.
- Throughput: a new request is accepted only in IDLE, so requests are spaced at least WAIT+3 cycles apart.
- Req while Busy=1 is ignored and not queued. If Req is still high on the edge after HOLD (state IDLE), it starts a new transaction.
- Changes on Addr/Wdata/Wr while Busy have no effect on the current transaction.
- Rdata holds its value until the next read completes. Writes never modify Rdata.
- Counter width is clog2(WAIT)+1; there is no wrap in normal operation. With WAIT=1, ACCESS lasts exactly one cycle.

Test Plan:
- Reset=0 during an active read in ACCESS -> all strobes inactive within the same cycle, Rdata=0, Busy=0, no Done/Rdata_Load pulses afterward.
- WAIT=2, read Addr=20'h00123 with SRAM model returning 16'hBEEF -> SETUP at cycle 1, OE_N low in cycles 2-3, Done and Rdata_Load high only in cycle 4, Rdata=16'hBEEF; the downstream register shows 16'hBEEF one edge later.
- Write Addr=20'h00040, Wdata=16'h1234 -> WE_N low in cycles 2-3, Mem_Dout=16'h1234 with Dout_En=1 in cycles 1-4, Done in cycle 4, Rdata_Load never asserts, Rdata unchanged.
- Req pulsed at cycle 2 of a busy transaction with a different Addr -> ignored; Mem_Addr stays at the original address; exactly one Done.
- Req held continuously high for two back-to-back reads (5555h, AAAAh) -> Done pulses 5 cycles apart (WAIT=2), Rdata sequence 16'h5555 then 16'hAAAA.
- WAIT=1 instance, single read -> Done in cycle 3, ACCESS lasts exactly one cycle.
